// File: rtl/tick_timer_arbiter.sv
// ---------------------------------------------------------------------------
// tick_timer_arbiter
//
// Shares one prescaled tick down-counter among NREQ requesters. An idle timer
// is granted to one requesting engine, which gets a one-cycle done pulse after
// D ticks of M clock cycles each. If the owner drops its request while the
// job runs, the job is cancelled and no done is issued.
//
// Build option:
//   TICK_TIMER_ARB_FIXED_PRIO_EN  - when defined, the lowest requesting index
//                                   always wins and there is no round-robin
//                                   pointer. Undefined (default): round-robin.
//
// Ports:
//   clk      in   1        system clock, rising edge
//   reset_n  in   1        asynchronous active-low reset
//   req      in   NREQ     level request per requester
//   delay    in   NREQ*N   packed delays, requester i at [i*N +: N]
//   gnt      out  NREQ     one-hot current owner, zero when idle
//   done     out  NREQ     one-cycle completion pulse to the owner
//   busy     out  1        timer in RUN or DONE
//   cnt      out  N        remaining ticks of the current job
// ---------------------------------------------------------------------------
module tick_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int N    = 8,
    parameter int M    = 10,
    parameter int PW   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] delay,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [N-1:0]      cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic [N-1:0]      cnt_q,   cnt_d;
    logic [PW-1:0]     pre_q,   pre_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;

    logic              any_req;
    logic [IW-1:0]     win;
    logic              tick;

`ifndef TICK_TIMER_ARB_FIXED_PRIO_EN
    logic [IW-1:0]     ptr_q,   ptr_d;
    logic [IW:0]       pos;
`endif

    assign tick = (pre_q == PW'(M - 1));

    // Winner selection. The loop runs from the farthest candidate down to the
    // nearest one so that the last match (the nearest) is the one kept.
    always_comb begin
        any_req = |req;
        win     = '0;
`ifdef TICK_TIMER_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win = IW'(i);
            end
        end
`else
        pos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_q} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            if (req[pos[IW-1:0]]) begin
                win = pos[IW-1:0];
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        gnt_d   = gnt_q;
`ifndef TICK_TIMER_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    idx_d      = win;
                    cnt_d      = delay[int'(win)*N +: N];
                    pre_d      = '0;
                    state_d    = S_RUN;
`ifndef TICK_TIMER_ARB_FIXED_PRIO_EN
                    ptr_d      = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
`endif
                end
            end
            S_RUN: begin
                pre_d = tick ? '0 : pre_q + PW'(1);
                // Cancellation wins over a final tick in the same cycle.
                if (!req[idx_q]) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else if (tick) begin
                    if (cnt_q == N'(1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - N'(1);
                    end
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
            gnt_q   <= '0;
`ifndef TICK_TIMER_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            gnt_q   <= gnt_d;
`ifndef TICK_TIMER_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign done = (state_q == S_DONE) ? gnt_q : '0;
    assign busy = (state_q != S_IDLE);
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
module tb_tick_timer_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 8;
    localparam int M    = 10;
    localparam int PW   = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] delay;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [N-1:0]      cnt;

    int errors = 0;
    int checks = 0;

    tick_timer_arbiter #(.NREQ(NREQ), .N(N), .M(M), .PW(PW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .delay   (delay),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int i, input logic [N-1:0] d);
        delay[i*N +: N] = d;
    endtask

    logic [NREQ-1:0] exp_g;
    logic            seen_done;

    initial begin
        reset_n = 1'b0;
        req     = '0;
        delay   = '0;
        #12;
        chk("rst_gnt",  32'(gnt),  32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt",  32'(cnt),  32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single job, D=3: done exactly 30 cycles after grant.
        set_delay(2, 8'd3);
        req = 4'b0100;
        step(1);
        chk("t1_gnt",  32'(gnt),  32'h4);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_cnt3", 32'(cnt),  32'd3);
        set_delay(2, 8'd7);             // ignored after grant
        step(10);
        chk("t1_cnt2", 32'(cnt), 32'd2);
        step(10);
        chk("t1_cnt1", 32'(cnt), 32'd1);
        step(9);
        chk("t1_nodone_early", 32'(done), 32'h0);
        step(1);
        chk("t1_done", 32'(done), 32'h4);
        chk("t1_cnt0", 32'(cnt),  32'd0);
        chk("t1_gnt_in_done", 32'(gnt), 32'h4);
        req = '0;
        step(1);
        chk("t1_gnt_off",  32'(gnt),  32'h0);
        chk("t1_done_off", 32'(done), 32'h0);
        chk("t1_busy_off", 32'(busy), 32'h0);

        // D=0: done on the cycle after grant.
        set_delay(0, 8'd0);
        req = 4'b0001;
        step(1);
        chk("t2_gnt", 32'(gnt), 32'h1);
        step(1);
        chk("t2_done", 32'(done), 32'h1);
        req = '0;
        step(1);
        chk("t2_busy", 32'(busy), 32'h0);

        // Pointer back to 0 for the rotation test.
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;

        // Rotation through all four requesters, D=1.
        for (int i = 0; i < NREQ; i++) set_delay(i, 8'd1);
        req = 4'b1111;
        for (int j = 0; j < NREQ; j++) begin
            step(1);
            exp_g = 4'b0001 << j;
            chk("t3_gnt", 32'(gnt), 32'(exp_g));
            step(9);
            chk("t3_nodone", 32'(done), 32'h0);
            step(1);
            chk("t3_done", 32'(done), 32'(exp_g));
            req[j] = 1'b0;
            step(1);
            chk("t3_idle", 32'(busy), 32'h0);
        end

        // Two competing requesters re-asserting after each done, D=2.
        set_delay(0, 8'd2);
        set_delay(3, 8'd2);
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            step(1);
`ifdef TICK_TIMER_ARB_FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
            chk("t4_gnt", 32'(gnt), 32'(exp_g));
            step(20);
            chk("t4_done", 32'(done), 32'(exp_g));
            req = req & ~exp_g;
            step(1);
            if (k < 3) req = req | exp_g;
        end
        req = '0;
        step(1);

        // Abort mid-run at cnt=5.
        set_delay(1, 8'd9);
        req = 4'b0010;
        step(1);
        chk("t5_gnt", 32'(gnt), 32'h2);
        step(40);
        chk("t5_cnt5", 32'(cnt), 32'd5);
        req = '0;
        step(1);
        chk("t5_gnt_off",  32'(gnt),  32'h0);
        chk("t5_busy_off", 32'(busy), 32'h0);
        chk("t5_cnt0",     32'(cnt),  32'h0);
        seen_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (done != '0) seen_done = 1'b1;
            step(1);
        end
        chk("t5_no_done", 32'(seen_done), 32'h0);

        // Abort coinciding with the final tick: abort wins.
        set_delay(2, 8'd1);
        req = 4'b0100;
        step(1);
        chk("t6_gnt", 32'(gnt), 32'h4);
        step(9);
        req = '0;
        step(1);
        chk("t6_done", 32'(done), 32'h0);
        chk("t6_gnt_off", 32'(gnt), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of a job.
        set_delay(0, 8'd6);
        req = 4'b0001;
        step(1);
        chk("t7_gnt", 32'(gnt), 32'h1);
        step(20);
        chk("t7_cnt4", 32'(cnt), 32'd4);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t7_rst_gnt",  32'(gnt),  32'h0);
        chk("t7_rst_done", 32'(done), 32'h0);
        chk("t7_rst_busy", 32'(busy), 32'h0);
        chk("t7_rst_cnt",  32'(cnt),  32'h0);
        req = '0;
        step(2);
        reset_n = 1'b1;
        set_delay(1, 8'd2);
        set_delay(3, 8'd2);
        req = 4'b1010;
        step(1);
        chk("t7_gnt_after_rst", 32'(gnt), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_timer_arbiter.md
Name: tick_timer_arbiter

Overview:
- Shares one prescaled tick down-counter among NREQ requesters. Each requester asks for a delay of D ticks.
- Round-robin arbitration picks the winner. The block loads and sequences the shared timer, then signals completion to the winner.
- Sits between several protocol engines (UART, debounce, PWM housekeeping) and one common timebase. This avoids one counter per engine.

Parameters:
- NREQ, 4, number of requesters (>=2)
- N, 8, delay counter width in bits
- M, 10, prescaler modulus; one tick every M clk cycles (M>=1)
- PW, 4, prescaler counter width; must satisfy 2**PW >= M

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester timer request (level); hold until done or abort
- delay  in  NREQ*N  packed delays; requester i uses bits [i*N +: N]; sampled at grant only
- gnt  out  NREQ  one-hot owner of the timer; all zero when idle
- done  out  NREQ  one-cycle completion pulse to the owner
- busy  out  1  timer in use (state RUN or DONE)
- cnt  out  N  remaining ticks of the current job

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: gnt=0, done=0, busy=0, cnt=0, prescaler=0, state=IDLE, rr pointer=0 (index 0 has highest priority).
- State machine: IDLE, RUN, DONE.

IDLE:
- If any req bit is set, choose the first set index searching upward from ptr, wrapping at NREQ-1→0.
- Next edge: gnt=onehot(idx), cnt=delay[idx], prescaler=0, state=RUN, ptr=(idx+1) mod NREQ.
- Latency: req sampled high in cycle t → gnt high in cycle t+1.

RUN:
- Prescaler counts 0..M-1 and wraps. tick = (prescaler==M-1). With M=1, tick fires every cycle.
- On tick with cnt>1: cnt decrements.
- On tick with cnt==1: cnt=0 and state=DONE.
- If cnt==0 on entry (D=0): state=DONE on the next edge regardless of tick.
- Timing: gnt first high in cycle g, D>0 → done high in cycle g+D*M. D=0 → done in cycle g+1.
- Abort: if req[idx] is low in any RUN cycle, the next edge sets gnt=0, cnt=0, state=IDLE, and no done is issued. Abort takes priority over a simultaneous final tick.

DONE:
- Held for one cycle: done[idx]=1, gnt still asserted, busy=1.
- Next edge: gnt=0, done=0, state=IDLE.

General rules:
- Requesters must drop req in the cycle after done. A req still high in IDLE is a new request.
- Back-to-back jobs: one idle cycle between DONE and the next grant.
- busy=1 exactly when state is RUN or DONE.
- delay changes after grant are ignored.
- Requests arriving during RUN/DONE wait; they are never lost while held.
- Reset asserted at any time returns all outputs to reset values immediately (asynchronously). An in-flight job is dropped with no done.

Optional Feature:
- Macro: TICK_TIMER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest set req index always wins, and ptr is neither used nor updated.
- Undefined (default): round-robin as described above.

Test Plan (NREQ=4, N=8, M=10):
- After reset, req=0100, delay[2]=3 → gnt=0100 next cycle, busy=1, cnt steps 3,2,1,0 every 10 cycles, done=0100 exactly 30 cycles after gnt rise; gnt=0 one cycle later.
- req=0001, delay[0]=0 → gnt=0001 at t+1, done=0001 at t+2, busy low at t+3.
- req=1111 held (each dropped after its done), all delays 1 → grants in order 0001, 0010, 0100, 1000; each job 10 RUN + 1 DONE + 1 IDLE cycle.
- req[0] and req[3] re-asserted after every done, delay 2 → grants alternate 0001, 1000, 0001, 1000 (with the macro defined: always 0001).
- req=0010, delay=9; drop req[1] when cnt=5 → gnt=0000 next edge, done never pulses, busy=0, cnt=0.
- reset_n low mid-RUN (cnt=4) → gnt, done, busy, cnt all 0 without waiting for a clk edge. After release, req=1010 → gnt=0010 (ptr back to 0).
